// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multiply sequencer: data width, register
// address width, sequencer state encoding and the iteration-count helper.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // Sequencer states: waiting for an issue, iterating, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Number of RUN cycles needed to consume all multiplier bits
    function automatic int MUL_ITERS(input int xlen, input int bits_per_cyc);
        return xlen / bits_per_cyc;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath.
// Holds the accumulator and the a/b shift registers. Each step adds
// a * (low BITS_PER_CYC bits of b) into the accumulator, then shifts a left
// and b right by BITS_PER_CYC. prod_next is the accumulator value that the
// current step will write, so the controller can capture the final product
// on the same edge as the last step. b_zero reports that the b value left
// after the current step is zero (used for early termination).
module mul_shift_add #(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] load_a,
    input  logic [XLEN-1:0] load_b,
    output logic [XLEN-1:0] prod_next,
    output logic            b_zero
);

    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;

    logic [XLEN-1:0] pp [BITS_PER_CYC];
    logic [XLEN-1:0] psum;
    logic [XLEN-1:0] a_shift;
    logic [XLEN-1:0] b_shift;

    // One shifted copy of a per multiplier bit consumed this cycle
    for (genvar gi = 0; gi < BITS_PER_CYC; gi++) begin : g_pp
        assign pp[gi] = b_q[gi] ? (a_q << gi) : '0;
    end

    // Sum the partial products of this cycle (overflow beyond XLEN dropped)
    always_comb begin
        psum = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            psum = psum + pp[i];
        end
    end

    assign a_shift   = a_q << BITS_PER_CYC;
    assign b_shift   = b_q >> BITS_PER_CYC;
    assign prod_next = acc_q + psum;
    assign b_zero    = (b_shift == '0);

    // Load clears the accumulator; step advances one iteration
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load) begin
            a_d   = load_a;
            b_d   = load_b;
            acc_d = '0;
        end else if (step) begin
            a_d   = a_shift;
            b_d   = b_shift;
            acc_d = prod_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the shared iterative multiplier placed after decode.
// Accepts one MUL at a time, runs mul_shift_add for a fixed number of
// cycles, flags RAW hazards against the pending destination and presents
// the product on a valid/ack writeback port. Destination r0 results are
// computed but silently dropped (no writeback, no hazard).
// Optional build macro: MUL_EARLY_EXIT_EN - terminate RUN as soon as the
// remaining multiplier bits are all zero.
module mul_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int XLEN         = cpu_pkg::XLEN,
    parameter int BITS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [XLEN-1:0]  issue_a,
    input  logic [XLEN-1:0]  issue_b,
    input  logic [REG_W-1:0] issue_rd,
    input  logic [REG_W-1:0] dec_ra,
    input  logic [REG_W-1:0] dec_rb,
    input  logic             dec_use_ra,
    input  logic             dec_use_rb,
    output logic             stall,
    output logic             busy,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    input  logic             wb_ack
);

    localparam int N     = MUL_ITERS(XLEN, BITS_PER_CYC);
    localparam int CNT_W = $clog2(N + 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [REG_W-1:0] pend_rd_q, pend_rd_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;

    logic             load;
    logic             step;
    logic             run_last;
    logic             early_exit;
    logic             hazard;
    logic             pend_live;
    logic [XLEN-1:0]  prod_next;
    logic             b_zero;

    mul_shift_add #(
        .XLEN         (XLEN),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .load_a    (issue_a),
        .load_b    (issue_b),
        .prod_next (prod_next),
        .b_zero    (b_zero)
    );

`ifdef MUL_EARLY_EXIT_EN
    // Stop once no multiplier bits remain after this cycle's add
    assign early_exit = b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
    assign early_exit    = 1'b0;
`endif

    // Last RUN cycle: iteration budget exhausted or nothing left to add
    assign run_last  = (count_q == CNT_W'(1)) || early_exit;
    assign pend_live = (pend_rd_q != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; r0 results bypass DONE entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_d = pend_live ? DONE : IDLE;
                end
            end
            DONE: begin
                if (wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from the registered state
    always_comb begin
        issue_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        wb_valid    = (state_q == DONE);
        load        = (state_q == IDLE) && issue_valid;
        step        = (state_q == RUN);
        hazard      = busy && pend_live &&
                      ((dec_use_ra && (dec_ra == pend_rd_q)) ||
                       (dec_use_rb && (dec_rb == pend_rd_q)));
        stall       = (issue_valid && !issue_ready) || hazard;
    end

    // Iteration count, pending destination and writeback capture
    always_comb begin
        count_d   = count_q;
        pend_rd_d = pend_rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (load) begin
            count_d   = CNT_W'(N);
            pend_rd_d = issue_rd;
        end else if (step) begin
            if (run_last) begin
                count_d = '0;
                if (pend_live) begin
                    wb_rd_d   = pend_rd_q;
                    wb_data_d = prod_next;
                end
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            pend_rd_q <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            count_q   <= count_d;
            pend_rd_q <= pend_rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard testbench for mul_seq_ctrl: directed scenarios plus randomized
// traffic; expected products and latencies come from a plain arithmetic
// reference model. Honors MUL_EARLY_EXIT_EN when defined.
module tb_mul_seq_ctrl;

    localparam int XW  = 32;
    localparam int BPC = 1;
    localparam int N   = XW / BPC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [XW-1:0] issue_a = '0;
    logic [XW-1:0] issue_b = '0;
    logic [4:0]    issue_rd = '0;
    logic [4:0]    dec_ra = '0;
    logic [4:0]    dec_rb = '0;
    logic          dec_use_ra = 1'b0;
    logic          dec_use_rb = 1'b0;
    logic          stall;
    logic          busy;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [XW-1:0] wb_data;
    logic          wb_ack;

    logic          ack_level = 1'b0;
    logic          rand_ack = 1'b0;
    logic          rand_bit = 1'b0;
    int            cyc = 0;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [4:0]    rd;
        logic [XW-1:0] data;
        int            acc_cyc;
        int            lat;
    } exp_t;

    exp_t sb[$];

    mul_seq_ctrl #(.XLEN(XW), .BITS_PER_CYC(BPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rd    (issue_rd),
        .dec_ra      (dec_ra),
        .dec_rb      (dec_rb),
        .dec_use_ra  (dec_use_ra),
        .dec_use_rb  (dec_use_rb),
        .stall       (stall),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ack      (wb_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end
    assign wb_ack = rand_ack ? rand_bit : ack_level;

    // Reference model: low XW bits of the full unsigned product
    function automatic logic [XW-1:0] ref_prod(input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic [2*XW-1:0] p;
        p = {{XW{1'b0}}, a} * {{XW{1'b0}}, b};
        return p[XW-1:0];
    endfunction

    // Reference model: RUN cycles from accept to result
    function automatic int ref_lat(input logic [XW-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int bits;
        bits = 0;
        for (int i = 0; i < XW; i++) begin
            if (b[i]) bits = i + 1;
        end
        if (bits == 0) return 1;
        return (bits + BPC - 1) / BPC;
`else
        return (b == b) ? N : N;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got timeout expected DUT event (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on each new result, checks hold while waiting
    task automatic monitor();
        logic          in_res;
        logic [4:0]    held_rd;
        logic [XW-1:0] held_data;
        exp_t          e;
        in_res = 1'b0;
        held_rd = '0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_res = 1'b0;
            end else if (wb_valid) begin
                if (!in_res) begin
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_wb: got rd=%0d data=%0h expected no result", wb_rd, wb_data);
                    end else begin
                        e = sb.pop_front();
                        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                        chk("wb_data", 64'(wb_data), 64'(e.data));
                        chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                        $display("wb rd=%0d data=%h latency=%0d", wb_rd, wb_data, cyc - e.acc_cyc);
                    end
                    held_rd = wb_rd;
                    held_data = wb_data;
                    in_res = 1'b1;
                end else begin
                    chk("wb_rd_stable", 64'(wb_rd), 64'(held_rd));
                    chk("wb_data_stable", 64'(wb_data), 64'(held_data));
                end
                if (wb_ack) in_res = 1'b0;
            end
        end
    endtask

    // Offer one MUL and hold it until accepted; records the expected result
    task automatic issue(input logic [XW-1:0] a, input logic [XW-1:0] b, input logic [4:0] rd);
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        issue_a = a;
        issue_b = b;
        issue_rd = rd;
        issue_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (issue_ready) break;
            n++;
            if (n > 300) begin
                timeout("issue_accept");
                issue_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        $display("issue a=%h b=%h rd=%0d", a, b, rd);
        if (rd != 5'd0) begin
            e.rd = rd;
            e.data = ref_prod(a, b);
            e.acc_cyc = cyc;
            e.lat = ref_lat(b);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 400) begin
                timeout("wait_idle");
                return;
            end
        end
    endtask

    // Issue one op and check stall on every busy cycle and the cycle after
    task automatic hazard_run(input logic [4:0] rd, input logic exp_stall, input string tag);
        int n;
        issue($urandom, $urandom | 32'h8000_0000, rd);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            chk(tag, 64'(stall), 64'(exp_stall));
            n++;
            if (n > 400) begin
                timeout(tag);
                return;
            end
        end
        chk({tag, "_after"}, 64'(stall), 64'(0));
    endtask

    initial begin
        int n;
        logic [XW-1:0] a;
        logic [XW-1:0] b;

        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog: got time limit expected end of test");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_rd", 64'(wb_rd), 64'(0));
        chk("rst_wb_data", 64'(wb_data), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_level = 1'b1;

        // Basic product and truncation
        issue(32'd7, 32'd6, 5'd3);
        wait_idle();
        chk("idle_after_ack", 64'(issue_ready), 64'(1));
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        wait_idle();

        // RAW hazard on ra, no hazard on unrelated ra, hazard on rb, rb unused
        dec_ra = 5'd5; dec_use_ra = 1'b1; dec_rb = 5'd0; dec_use_rb = 1'b0;
        hazard_run(5'd5, 1'b1, "stall_ra_match");
        dec_ra = 5'd6;
        hazard_run(5'd5, 1'b0, "stall_ra_other");
        dec_ra = 5'd0; dec_use_ra = 1'b0; dec_rb = 5'd17; dec_use_rb = 1'b1;
        hazard_run(5'd17, 1'b1, "stall_rb_match");
        dec_use_rb = 1'b0;
        hazard_run(5'd17, 1'b0, "stall_rb_unused");

        // Backpressure: result held, second issue stalled
        ack_level = 1'b0;
        issue($urandom, $urandom, 5'd12);
        n = 0;
        forever begin
            @(negedge clk);
            if (wb_valid) break;
            n++;
            if (n > 400) begin
                timeout("bp_wb_valid");
                break;
            end
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        issue_a = $urandom; issue_b = $urandom; issue_rd = 5'd2;
        issue_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall", 64'(stall), 64'(1));
        chk("bp_issue_ready", 64'(issue_ready), 64'(0));
        chk("bp_wb_valid_held", 64'(wb_valid), 64'(1));
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        ack_level = 1'b1;
        wait_idle();

        // rd = 0: runs, never writes back, never stalls on r0
        dec_ra = 5'd0; dec_use_ra = 1'b1; dec_rb = 5'd0; dec_use_rb = 1'b1;
        issue(32'd3, 32'd4, 5'd0);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            chk("rd0_stall", 64'(stall), 64'(0));
            chk("rd0_wb_valid", 64'(wb_valid), 64'(0));
            n++;
            if (n > 400) begin
                timeout("rd0_busy");
                break;
            end
        end
        chk("rd0_busy_cycles", 64'(n), 64'(ref_lat(32'd4)));
        dec_use_ra = 1'b0; dec_use_rb = 1'b0;

        // b = 1: product equals a; latency 1 with early exit, N otherwise
        issue(32'hDEAD_BEEF, 32'd1, 5'd4);
        wait_idle();

        // Reset mid-RUN abandons the operation
        issue($urandom, $urandom | 32'h8000_0000, 5'd7);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_wb_valid", 64'(wb_valid), 64'(0));
        chk("midrst_issue_ready", 64'(issue_ready), 64'(1));
        chk("midrst_wb_data", 64'(wb_data), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_no_wb", 64'(wb_valid), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Randomized traffic with random writeback backpressure
        rand_ack = 1'b1;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom >> $urandom_range(0, 31);
                2: b = '0;
                default: b = 32'd1;
            endcase
            issue(a, b, 5'($urandom_range(0, 31)));
        end
        wait_idle();
        rand_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the shared iterative shift-add multiplier, placed after decode. It accepts MUL operations (decode's `D_mul`) with operand values and destination register, then runs the multiplier for a fixed number of cycles. It raises pipeline stalls on RAW hazards against the pending destination and on issue-while-busy. It presents the product on a valid/ack writeback port, which the writeback mux grants when the ALU slot is free.

## Interface
- `XLEN`, 32, operand and result width.
- `BITS_PER_CYC`, 1, multiplier bits consumed per RUN cycle; must divide `XLEN`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: MUL instruction offered.
- `issue_ready` out 1: sequencer can accept.
- `issue_a` in XLEN: multiplicand (ra value).
- `issue_b` in XLEN: multiplier (rb value).
- `issue_rd` in 5: destination register.
- `dec_ra` in 5: source A of the instruction in decode.
- `dec_rb` in 5: source B of the instruction in decode.
- `dec_use_ra` in 1: decode reads ra.
- `dec_use_rb` in 1: decode reads rb.
- `stall` out 1: freeze fetch/decode.
- `busy` out 1: state != IDLE.
- `wb_valid` out 1: product ready for writeback.
- `wb_rd` out 5: destination register.
- `wb_data` out XLEN: product.
- `wb_ack` in 1: writeback mux consumed the result.

## Operation
- State machine with three states:
  - IDLE: `issue_ready`=1. On `issue_valid`, latch a, b and rd, clear the accumulator, set iteration count N=`XLEN/BITS_PER_CYC`, go to RUN.
  - RUN: each cycle, add (a × low `BITS_PER_CYC` bits of b) to the accumulator, shift a left and b right by `BITS_PER_CYC`, decrement the count. When the count reaches 0, go to DONE.
  - DONE: `wb_valid`=1 and held stable until `wb_ack`. On `wb_ack`, go to IDLE.
- Arithmetic: unsigned multiply truncated to the low `XLEN` bits, which equals the signed low half. Accumulator and shifted a are `XLEN` wide; overflow is discarded.
- rd = 0: the operation runs normally, but DONE is skipped. RUN exits directly to IDLE, `wb_valid` never asserts, and no hazard is flagged.
- `stall` is combinational and is asserted when either condition holds:
  - issue-while-busy: `issue_valid` && !`issue_ready`.
  - RAW hazard: `busy` && pend_rd != 0 && ((`dec_use_ra` && `dec_ra`==pend_rd) || (`dec_use_rb` && `dec_rb`==pend_rd)).
- `wb_ack` while `wb_valid`=0 is ignored.
- `issue_valid` outside IDLE is not accepted; the stall covers it.

## Timing
- Accept at edge 0 (IDLE && `issue_valid`).
- RUN occupies edges 1..N; DONE is entered at edge N, so `wb_valid` is first high in the cycle after edge N.
- Latency from accept to `wb_valid` is N cycles: 32 at the defaults.
- The `wb_ack` edge returns to IDLE; the next issue can be accepted one cycle later. No back-to-back issue in the ack cycle.
- `issue_ready`, `busy`, `wb_valid` and `stall` are decoded from registered state. `wb_rd` and `wb_data` are registered.
- Reset values: state IDLE, `issue_ready`=1, `busy`=0, `stall`=0 (absent `issue_valid`), `wb_valid`=0, `wb_rd`=0, `wb_data`=0, accumulator and count 0.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned immediately, with no `wb_valid` after release.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - RUN also exits when the remaining shifted b == 0, checked after the current cycle's add.
  - b=0 at issue exits after one RUN cycle with product 0.
  - Latency is ceil(msb_index(b)+1, `BITS_PER_CYC`)/`BITS_PER_CYC` cycles, minimum 1.
- Undefined: always exactly N RUN cycles.

## Structure
- Shared package `cpu_pkg`: `XLEN`, register address width (5), state enum (IDLE/RUN/DONE), `MUL_ITERS` function.
- One sub-module, `mul_shift_add`: accumulator, a/b shift registers and a `BITS_PER_CYC` partial-product adder, with load/step controls and a b_zero flag.
- The FSM, hazard compare and writeback register stay in `mul_seq_ctrl`.

## Test plan
- Basic product: issue a=7, b=6, rd=3, `wb_ack` tied 1 → `wb_valid` 32 cycles after accept, `wb_data`=42, `wb_rd`=3, IDLE on the next edge.
- Truncation: a=0xFFFFFFFF, b=0xFFFFFFFF → `wb_data`=0x00000001.
- Hazard: MUL into rd=5, decode shows `dec_ra`=5 with `dec_use_ra`=1 → `stall`=1 through RUN and DONE, 0 the cycle after `wb_ack`. With `dec_ra`=6 → `stall`=0.
- Backpressure: `wb_ack` held 0 for 10 cycles after `wb_valid` → `wb_valid`, `wb_data` and `wb_rd` stable throughout; a second `issue_valid` → `stall`=1 and `issue_ready`=0.
- rd=0: issue a=3, b=4, rd=0 → no `wb_valid`, `busy` falls after 32 RUN cycles, and `dec_ra`=0 never stalls.
- Reset / early exit:
  - Assert `rst_n`=0 at RUN cycle 10 → `busy`=0 and `wb_valid`=0 immediately, and no result after release.
  - With `MUL_EARLY_EXIT_EN`, b=1 → `wb_valid` 1 cycle after accept with `wb_data`=a.
